// File: rtl/meas_seq_ctrl_if.sv
// Control/status bundle between the trigger/init logic and meas_seq_ctrl.
// master = trigger/init side (drives start, abort, mask), slave = sequencer.
interface meas_seq_ctrl_if #(
  parameter int RF_CH = 4,
  parameter int ROT_W = 10
);
  localparam int IDX_W = (RF_CH > 1) ? $clog2(RF_CH) : 1;

  logic             trg_ctrl;
  logic             abort;
  logic [RF_CH-1:0] ch_mask;
  logic             wrk_stat;
  logic             rot_en;
  logic             adc_en;
  logic [RF_CH-1:0] rf_sw;
  logic [IDX_W-1:0] rf_ch_idx;
  logic             meas_valid;
  logic [ROT_W-1:0] rot_count;
  logic             done;

  modport master (
    output trg_ctrl, abort, ch_mask,
    input  wrk_stat, rot_en, adc_en, rf_sw, rf_ch_idx, meas_valid, rot_count, done
  );

  modport slave (
    input  trg_ctrl, abort, ch_mask,
    output wrk_stat, rot_en, adc_en, rf_sw, rf_ch_idx, meas_valid, rot_count, done
  );
endinterface

// File: rtl/meas_seq_ctrl.sv
// Rotation-step + masked RF channel / ADC window sequencer; CONT_SCAN_EN wraps the run at ROT_TARGET.
// All outputs registered, one edge from input to effect; no backpressure, abort ends a run next edge.
module meas_seq_ctrl #(
  parameter int RF_CH         = 4,
  parameter int ROT_PULSE_LEN = 5,
  parameter int SETTLE_CYC    = 100,
  parameter int ADC_GUARD     = 3,
  parameter int ADC_WIN       = 30,
  parameter int ROT_TARGET    = 720,
  parameter int ROT_W         = 10
) (
  input  logic               stp_clk,
  input  logic               sys_init_ctrl,
  meas_seq_ctrl_if.slave     bus
);

  localparam int IDX_W   = (RF_CH > 1) ? $clog2(RF_CH) : 1;
  localparam int MAX_AB  = (ROT_PULSE_LEN > SETTLE_CYC) ? ROT_PULSE_LEN : SETTLE_CYC;
  localparam int MAX_CD  = (ADC_GUARD > ADC_WIN) ? ADC_GUARD : ADC_WIN;
  localparam int TMR_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  // Timer counts down to zero, so a state of length N is loaded with N-1.
  localparam logic [TMR_W-1:0] T_ROT    = TMR_W'(ROT_PULSE_LEN - 1);
  localparam logic [TMR_W-1:0] T_SETTLE = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] T_GUARD  = TMR_W'(ADC_GUARD - 1);
  localparam logic [TMR_W-1:0] T_WIN    = TMR_W'(ADC_WIN - 1);
  localparam logic [ROT_W-1:0] ROT_TGT  = ROT_W'(ROT_TARGET);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROTATE,
    S_SETTLE,
    S_GUARD,
    S_SAMPLE
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [RF_CH-1:0] mask_q, mask_d;
  logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
  logic             wrk_q, wrk_d;
  logic             rot_en_q, rot_en_d;
  logic             adc_en_q, adc_en_d;
  logic [RF_CH-1:0] rf_sw_q, rf_sw_d;
  logic [IDX_W-1:0] rf_idx_q, rf_idx_d;
  logic             meas_vld_q, meas_vld_d;
  logic [ROT_W-1:0] rot_cnt_q, rot_cnt_d;
  logic             done_q, done_d;

  logic             tmr_done;
  logic [IDX_W:0]   pick;
  logic [ROT_W-1:0] cnt_inc;

  // Lowest set bit of m at or above index from; MSB of the result flags a hit.
  function automatic logic [IDX_W:0] pick_ch(input logic [RF_CH-1:0] m, input int from);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = RF_CH - 1; i >= 0; i--) begin
      if (m[i] && (i >= from)) r = {1'b1, IDX_W'(i)};
    end
    return r;
  endfunction

  function automatic logic [RF_CH-1:0] fix_mask(input logic [RF_CH-1:0] m);
    return (m == '0) ? RF_CH'(1) : m;
  endfunction

  function automatic logic [RF_CH-1:0] onehot(input logic [IDX_W-1:0] idx);
    return RF_CH'(1) << idx;
  endfunction

  assign tmr_done = (timer_q == '0);
  assign cnt_inc  = rot_cnt_q + ROT_W'(1);

  always_comb begin
    state_d    = state_q;
    timer_d    = tmr_done ? timer_q : timer_q - TMR_W'(1);
    mask_d     = mask_q;
    cur_idx_d  = cur_idx_q;
    wrk_d      = wrk_q;
    rot_en_d   = rot_en_q;
    adc_en_d   = adc_en_q;
    rf_sw_d    = rf_sw_q;
    rf_idx_d   = rf_idx_q;
    meas_vld_d = 1'b0;
    rot_cnt_d  = rot_cnt_q;
    done_d     = 1'b0;
    pick       = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.trg_ctrl) begin
          wrk_d     = 1'b1;
          rot_en_d  = 1'b1;
          rot_cnt_d = '0;
          mask_d    = fix_mask(bus.ch_mask);
          timer_d   = T_ROT;
          state_d   = S_ROTATE;
        end
      end

      S_ROTATE: begin
        if (tmr_done) begin
          rot_en_d = 1'b0;
          timer_d  = T_SETTLE;
          state_d  = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (tmr_done) begin
          pick      = pick_ch(mask_q, 0);
          cur_idx_d = pick[IDX_W-1:0];
          rf_idx_d  = pick[IDX_W-1:0];
          rf_sw_d   = onehot(pick[IDX_W-1:0]);
          timer_d   = T_GUARD;
          state_d   = S_GUARD;
        end
      end

      S_GUARD: begin
        // Catches rf_ch_idx up one cycle after a SAMPLE->GUARD channel switch.
        rf_idx_d = cur_idx_q;
        if (tmr_done) begin
          adc_en_d = 1'b1;
          timer_d  = T_WIN;
          state_d  = S_SAMPLE;
        end
      end

      S_SAMPLE: begin
        if (tmr_done) begin
          adc_en_d   = 1'b0;
          meas_vld_d = 1'b1;
          pick       = pick_ch(mask_q, int'(cur_idx_q) + 1);
          if (pick[IDX_W]) begin
            cur_idx_d = pick[IDX_W-1:0];
            rf_sw_d   = onehot(pick[IDX_W-1:0]);
            timer_d   = T_GUARD;
            state_d   = S_GUARD;
          end else begin
            rf_sw_d = '0;
            if (cnt_inc == ROT_TGT) begin
              done_d = 1'b1;
`ifdef CONT_SCAN_EN
              rot_cnt_d = '0;
              rot_en_d  = 1'b1;
              mask_d    = fix_mask(bus.ch_mask);
              timer_d   = T_ROT;
              state_d   = S_ROTATE;
`else
              rot_cnt_d = cnt_inc;
              wrk_d     = 1'b0;
              timer_d   = '0;
              state_d   = S_IDLE;
`endif
            end else begin
              rot_cnt_d = cnt_inc;
              rot_en_d  = 1'b1;
              mask_d    = fix_mask(bus.ch_mask);
              timer_d   = T_ROT;
              state_d   = S_ROTATE;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase

    // Abort overrides everything above but keeps the step count and channel bookkeeping.
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      timer_d    = '0;
      mask_d     = mask_q;
      cur_idx_d  = cur_idx_q;
      rf_idx_d   = rf_idx_q;
      wrk_d      = 1'b0;
      rot_en_d   = 1'b0;
      adc_en_d   = 1'b0;
      rf_sw_d    = '0;
      meas_vld_d = 1'b0;
      rot_cnt_d  = rot_cnt_q;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge stp_clk) begin
    if (sys_init_ctrl) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      mask_q     <= '0;
      cur_idx_q  <= '0;
      wrk_q      <= 1'b0;
      rot_en_q   <= 1'b0;
      adc_en_q   <= 1'b0;
      rf_sw_q    <= '0;
      rf_idx_q   <= '0;
      meas_vld_q <= 1'b0;
      rot_cnt_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      mask_q     <= mask_d;
      cur_idx_q  <= cur_idx_d;
      wrk_q      <= wrk_d;
      rot_en_q   <= rot_en_d;
      adc_en_q   <= adc_en_d;
      rf_sw_q    <= rf_sw_d;
      rf_idx_q   <= rf_idx_d;
      meas_vld_q <= meas_vld_d;
      rot_cnt_q  <= rot_cnt_d;
      done_q     <= done_d;
    end
  end

  assign bus.wrk_stat   = wrk_q;
  assign bus.rot_en     = rot_en_q;
  assign bus.adc_en     = adc_en_q;
  assign bus.rf_sw      = rf_sw_q;
  assign bus.rf_ch_idx  = rf_idx_q;
  assign bus.meas_valid = meas_vld_q;
  assign bus.rot_count  = rot_cnt_q;
  assign bus.done       = done_q;

  a_rot_adc_excl: assert property (@(posedge stp_clk) !(rot_en_q && adc_en_q));
  a_sw_quiet:     assert property (@(posedge stp_clk) disable iff (sys_init_ctrl)
                                   (rf_sw_d != rf_sw_q) |-> !adc_en_d);
  a_mask_live:    assert property (@(posedge stp_clk) disable iff (sys_init_ctrl)
                                   (state_q != S_IDLE) |-> (mask_q != '0));

endmodule

// File: tb/tb_meas_seq_ctrl.sv
// Directed bench for meas_seq_ctrl: cycle-indexed expectation table plus reset/abort/restart/mask-change sequences.
module tb_meas_seq_ctrl;

`ifdef CONT_SCAN_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic       stp_clk = 1'b0;
  logic       rst     = 1'b1;
  logic       trg     = 1'b0;
  logic       abrt    = 1'b0;
  logic [3:0] msk     = 4'h0;

  always #5 stp_clk = ~stp_clk;

  meas_seq_ctrl_if #(.RF_CH(4), .ROT_W(10)) b1 ();
  meas_seq_ctrl_if #(.RF_CH(4), .ROT_W(10)) b2 ();

  assign b1.trg_ctrl = trg;
  assign b1.abort    = abrt;
  assign b1.ch_mask  = msk;
  assign b2.trg_ctrl = trg;
  assign b2.abort    = abrt;
  assign b2.ch_mask  = msk;

  meas_seq_ctrl #(.RF_CH(4), .ROT_TARGET(2), .ROT_W(10)) dut (
    .stp_clk       (stp_clk),
    .sys_init_ctrl (rst),
    .bus           (b1)
  );

  meas_seq_ctrl #(.RF_CH(4), .ROT_TARGET(3), .ROT_W(10)) dut3 (
    .stp_clk       (stp_clk),
    .sys_init_ctrl (rst),
    .bus           (b2)
  );

  typedef struct {
    logic [3:0] mask;
    int         cyc;
    logic       rot_en;
    logic       adc_en;
    logic [3:0] rf_sw;
    logic [1:0] idx;
    logic       mv;
    logic       wrk;
    logic [9:0] rc;
    logic       done;
  } vec_t;

  vec_t       tbl[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cur = 0;
  logic [3:0] cur_mask = 4'h0;
  int         inv_err = 0;
  logic [3:0] sw1_prev = 4'h0;
  logic [3:0] sw2_prev = 4'h0;

  function automatic vec_t mk(input logic [3:0] m, input int c, input logic re, input logic ae,
                              input logic [3:0] sw, input logic [1:0] ix, input logic mv,
                              input logic wk, input int rc, input logic dn);
    vec_t v;
    v.mask = m; v.cyc = c; v.rot_en = re; v.adc_en = ae; v.rf_sw = sw; v.idx = ix;
    v.mv = mv; v.wrk = wk; v.rc = 10'(rc); v.done = dn;
    return v;
  endfunction

  function automatic logic [20:0] pack1();
    return {b1.rot_en, b1.adc_en, b1.rf_sw, b1.rf_ch_idx, b1.meas_valid, b1.wrk_stat, b1.rot_count, b1.done};
  endfunction

  function automatic bit viol(input logic re, input logic ae, input logic [3:0] sw, input logic [3:0] prev);
    return (re && ae) || (ae && (sw != prev)) || ((sw & (sw - 4'd1)) != 4'd0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic start_run(input logic [3:0] m, input bit hold);
    @(negedge stp_clk); rst = 1'b1; trg = 1'b0; abrt = 1'b0;
    @(negedge stp_clk); rst = 1'b0; msk = m; trg = 1'b1;
    @(negedge stp_clk); if (!hold) trg = 1'b0;
    cur = 1; cur_mask = m;
  endtask

  task automatic advance(input int c);
    if (c > cur) repeat (c - cur) @(negedge stp_clk);
    cur = c;
  endtask

  // Invariants watched on every cycle of both instances.
  always @(negedge stp_clk) begin
    if (viol(b1.rot_en, b1.adc_en, b1.rf_sw, sw1_prev) || viol(b2.rot_en, b2.adc_en, b2.rf_sw, sw2_prev))
      inv_err <= inv_err + 1;
    sw1_prev <= b1.rf_sw;
    sw2_prev <= b2.rf_sw;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d2;
    bit first;
    logic [20:0] exp_v, act_v;

    //            mask  cyc  ren aen rf_sw idx mv wrk rc done
    tbl.push_back(mk(4'hF,   1, 1, 0, 4'h0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(4'hF,   5, 1, 0, 4'h0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(4'hF,   6, 0, 0, 4'h0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(4'hF, 105, 0, 0, 4'h0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(4'hF, 106, 0, 0, 4'h1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(4'hF, 108, 0, 0, 4'h1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(4'hF, 109, 0, 1, 4'h1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(4'hF, 138, 0, 1, 4'h1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(4'hF, 139, 0, 0, 4'h2, 0, 1, 1, 0, 0));
    tbl.push_back(mk(4'hF, 140, 0, 0, 4'h2, 1, 0, 1, 0, 0));
    tbl.push_back(mk(4'hF, 142, 0, 1, 4'h2, 1, 0, 1, 0, 0));
    tbl.push_back(mk(4'hF, 172, 0, 0, 4'h4, 1, 1, 1, 0, 0));
    tbl.push_back(mk(4'hF, 205, 0, 0, 4'h8, 2, 1, 1, 0, 0));
    tbl.push_back(mk(4'hF, 237, 0, 1, 4'h8, 3, 0, 1, 0, 0));
    tbl.push_back(mk(4'hF, 238, 1, 0, 4'h0, 3, 1, 1, 1, 0));
    tbl.push_back(mk(4'hF, 242, 1, 0, 4'h0, 3, 0, 1, 1, 0));
    tbl.push_back(mk(4'hF, 243, 0, 0, 4'h0, 3, 0, 1, 1, 0));
    tbl.push_back(mk(4'hF, 474, 0, 1, 4'h8, 3, 0, 1, 1, 0));
    tbl.push_back(mk(4'hF, 475, CONT, 0, 4'h0, 3, 1, CONT, CONT ? 0 : 2, 1));
    tbl.push_back(mk(4'hF, 476, CONT, 0, 4'h0, 3, 0, CONT, CONT ? 0 : 2, 0));
    tbl.push_back(mk(4'hF, 712, CONT, 0, 4'h0, 3, CONT, CONT, CONT ? 1 : 2, 0));
    tbl.push_back(mk(4'hA, 106, 0, 0, 4'h2, 1, 0, 1, 0, 0));
    tbl.push_back(mk(4'hA, 139, 0, 0, 4'h8, 1, 1, 1, 0, 0));
    tbl.push_back(mk(4'hA, 140, 0, 0, 4'h8, 3, 0, 1, 0, 0));
    tbl.push_back(mk(4'hA, 171, 0, 1, 4'h8, 3, 0, 1, 0, 0));
    tbl.push_back(mk(4'hA, 172, 1, 0, 4'h0, 3, 1, 1, 1, 0));
    tbl.push_back(mk(4'hA, 277, 0, 0, 4'h2, 1, 0, 1, 1, 0));
    tbl.push_back(mk(4'hA, 343, CONT, 0, 4'h0, 3, 1, CONT, CONT ? 0 : 2, 1));
    tbl.push_back(mk(4'h0, 106, 0, 0, 4'h1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(4'h0, 138, 0, 1, 4'h1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(4'h0, 139, 1, 0, 4'h0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(4'h0, 277, CONT, 0, 4'h0, 0, 1, CONT, CONT ? 0 : 2, 1));

    repeat (3) @(negedge stp_clk);
    chk("reset_outputs", 32'(pack1()), 32'd0);

    first = 1'b1;
    foreach (tbl[i]) begin
      if (first || tbl[i].mask != cur_mask || tbl[i].cyc < cur) start_run(tbl[i].mask, 1'b0);
      first = 1'b0;
      advance(tbl[i].cyc);
      exp_v = {tbl[i].rot_en, tbl[i].adc_en, tbl[i].rf_sw, tbl[i].idx, tbl[i].mv, tbl[i].wrk, tbl[i].rc, tbl[i].done};
      act_v = pack1();
      n_chk++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL row%0d mask=%h cyc=%0d: got ren=%b aen=%b sw=%b idx=%0d mv=%b wrk=%b rc=%0d done=%b, expected ren=%b aen=%b sw=%b idx=%0d mv=%b wrk=%b rc=%0d done=%b",
                 i, tbl[i].mask, tbl[i].cyc, b1.rot_en, b1.adc_en, b1.rf_sw, b1.rf_ch_idx, b1.meas_valid,
                 b1.wrk_stat, b1.rot_count, b1.done, tbl[i].rot_en, tbl[i].adc_en, tbl[i].rf_sw, tbl[i].idx,
                 tbl[i].mv, tbl[i].wrk, tbl[i].rc, tbl[i].done);
      end
    end

    // Reset in the middle of step 2's first ADC window.
    start_run(4'hF, 1'b0);
    advance(350);
    chk("pre_reset_rc", 32'(b1.rot_count), 32'd1);
    chk("pre_reset_adc", 32'(b1.adc_en), 32'd1);
    rst = 1'b1;
    @(negedge stp_clk);
    rst = 1'b0;
    chk("reset_mid_sample", 32'(pack1()), 32'd0);
    repeat (3) @(negedge stp_clk);
    chk("reset_stays_idle", 32'(pack1()), 32'd0);
    trg = 1'b1;
    @(negedge stp_clk);
    trg = 1'b0;
    chk("restart_after_reset", 32'({b1.rot_en, b1.wrk_stat, b1.rot_count}), 32'({1'b1, 1'b1, 10'd0}));

    // Abort landing on the edge that would close the first window.
    start_run(4'hF, 1'b0);
    advance(138);
    abrt = 1'b1;
    @(negedge stp_clk);
    abrt = 1'b0;
    chk("abort_at_window_end", 32'(pack1()), 32'd0);
    repeat (5) @(negedge stp_clk);
    chk("abort_stays_idle", 32'({b1.wrk_stat, b1.rot_en}), 32'd0);

    // Abort during SETTLE of step 3 on the ROT_TARGET=3 instance.
    start_run(4'h0, 1'b0);
    advance(300);
    chk("t3_pre_abort", 32'({b2.wrk_stat, b2.rot_count}), 32'({1'b1, 10'd2}));
    abrt = 1'b1;
    @(negedge stp_clk);
    abrt = 1'b0;
    chk("t3_abort_outputs", 32'({b2.wrk_stat, b2.rot_en, b2.adc_en, b2.rf_sw, b2.meas_valid, b2.rot_count}),
        32'({1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 10'd2}));
    d2 = 0;
    repeat (150) begin
      @(negedge stp_clk);
      if (b2.done) d2++;
    end
    chk("t3_no_done_after_abort", 32'(d2), 32'd0);
    chk("t3_count_held", 32'(b2.rot_count), 32'd2);

    // trg held high through done restarts on the first IDLE cycle.
    start_run(4'h0, 1'b1);
    advance(277);
    chk("held_trg_done", 32'({b1.done, b1.wrk_stat}), 32'({1'b1, CONT}));
    advance(278);
    trg = 1'b0;
    chk("held_trg_restart", 32'({b1.rot_en, b1.wrk_stat, b1.rot_count, b1.done}), 32'({1'b1, 1'b1, 10'd0, 1'b0}));

    // Mid-step mask change and stray trg: only the next ROTATE picks up the new mask.
    start_run(4'hA, 1'b0);
    advance(50);
    msk = 4'h1;
    trg = 1'b1;
    advance(51);
    trg = 1'b0;
    advance(106);
    chk("mask_change_old_step", 32'({b1.rf_sw, b1.rf_ch_idx, b1.rot_count}), 32'({4'h2, 2'd1, 10'd0}));
    advance(172);
    chk("mask_change_step_end", 32'(b1.rot_count), 32'd1);
    advance(277);
    chk("mask_change_new_step", 32'({b1.rf_sw, b1.rf_ch_idx}), 32'({4'h1, 2'd0}));

    chk("invariants", 32'(inv_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
